// File: rtl/sampctrl_if.sv
// sampctrl_if: handshake and analog-control bundle between the SAR sequencer
// and its surroundings (readout logic, sampling driver, comparator, CDAC).
//   start, samp_len    : conversion request and sample-phase length (readout side)
//   comp_out           : comparator decision, 1 = input >= DAC (analog side)
//   samp_clk, comp_clk : sampling phase and comparator strobe (to analog core)
//   dac_state          : CDAC code of kept bits plus the current trial bit
//   busy, done, result : conversion status and final code (to readout side)
// The master modport is the environment; the slave modport is the sequencer.
interface sampctrl_if #(
    parameter int N_BITS = 8,
    parameter int SAMP_W = 4
);
    logic              start;
    logic [SAMP_W-1:0] samp_len;
    logic              comp_out;
    logic              samp_clk;
    logic              comp_clk;
    logic [N_BITS-1:0] dac_state;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    modport master (
        output start, samp_len, comp_out,
        input  samp_clk, comp_clk, dac_state, busy, done, result
    );

    modport slave (
        input  start, samp_len, comp_out,
        output samp_clk, comp_clk, dac_state, busy, done, result
    );
endinterface

// File: rtl/sampctrl.sv
// sampctrl: SAR conversion sequencer. Generates the sampling phase, the
// comparator strobe and the CDAC trial code, runs the MSB-first binary
// search and reports the final code.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset (priority over start)
//   bus    : sampctrl_if.slave (start, samp_len, comp_out in;
//            samp_clk, comp_clk, dac_state, busy, done, result out)
//   vdd_d, vss_d : digital supply pins, no logic function
// Every output is a register loaded with the value belonging to the state
// being entered, so outputs change exactly on the state transition edge.
module sampctrl #(
    parameter int N_BITS = 8,
    parameter int SAMP_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    sampctrl_if.slave  bus,
    inout  wire        vdd_d,
    inout  wire        vss_d
);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COMP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [SAMP_W-1:0] scnt_r;
    logic [N_BITS-1:0] kept_r;
    logic [N_BITS-1:0] dac_r;
    logic [N_BITS-1:0] result_r;
    logic              samp_clk_r;
    logic              comp_clk_r;
    logic              busy_r;
    logic              done_r;

    logic [N_BITS-1:0] kept_next_s;
    logic [N_BITS-1:0] next_trial_s;
    logic [SAMP_W-1:0] samp_len_s;

    // One-hot mask selecting bit i of the code.
    function automatic logic [N_BITS-1:0] bit_mask(input logic [IDX_W-1:0] i);
        logic [N_BITS-1:0] m;
        m    = {N_BITS{1'b0}};
        m[i] = 1'b1;
        return m;
    endfunction

    // Comparator decision folded into the kept code, next trial code, and
    // the sample length with 0 mapped to 1.
    always_comb begin
        kept_next_s  = kept_r;
        next_trial_s = {N_BITS{1'b0}};
        samp_len_s   = bus.samp_len;
        if (bus.comp_out) begin
            kept_next_s = kept_r | bit_mask(idx_r);
        end else begin
            kept_next_s = kept_r & ~bit_mask(idx_r);
        end
        if (idx_r != {IDX_W{1'b0}}) begin
            next_trial_s = kept_next_s | bit_mask(idx_r - IDX_W'(1));
        end else begin
            next_trial_s = kept_next_s;
        end
        if (bus.samp_len == {SAMP_W{1'b0}}) begin
            samp_len_s = SAMP_W'(1);
        end else begin
            samp_len_s = bus.samp_len;
        end
    end

    // Conversion state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            scnt_r     <= {SAMP_W{1'b0}};
            kept_r     <= {N_BITS{1'b0}};
            dac_r      <= {N_BITS{1'b0}};
            result_r   <= {N_BITS{1'b0}};
            samp_clk_r <= 1'b0;
            comp_clk_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    comp_clk_r <= 1'b0;
                    done_r     <= 1'b0;
                    dac_r      <= {N_BITS{1'b0}};
                    if (bus.start) begin
                        state_r    <= ST_SAMPLE;
                        scnt_r     <= samp_len_s;
                        kept_r     <= {N_BITS{1'b0}};
                        samp_clk_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        samp_clk_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    // scnt_r holds the cycles left including the current one.
                    if (scnt_r == SAMP_W'(1)) begin
                        state_r    <= ST_SETTLE;
                        idx_r      <= IDX_W'(N_BITS - 1);
                        samp_clk_r <= 1'b0;
                        dac_r      <= kept_r | bit_mask(IDX_W'(N_BITS - 1));
                    end else begin
                        state_r    <= ST_SAMPLE;
                        scnt_r     <= scnt_r - SAMP_W'(1);
                    end
                end
                ST_SETTLE: begin
                    state_r    <= ST_COMP;
                    comp_clk_r <= 1'b1;
                end
                ST_COMP: begin
                    comp_clk_r <= 1'b0;
                    kept_r     <= kept_next_s;
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_r  <= ST_DONE;
                        result_r <= kept_next_s;
                        dac_r    <= kept_next_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_SETTLE;
                        idx_r    <= idx_r - IDX_W'(1);
                        dac_r    <= next_trial_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    samp_clk_r <= 1'b0;
                    comp_clk_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    dac_r      <= {N_BITS{1'b0}};
                end
            endcase
        end
    end

    assign bus.samp_clk  = samp_clk_r;
    assign bus.comp_clk  = comp_clk_r;
    assign bus.dac_state = dac_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
endmodule

// File: doc/sampctrl.md
# sampctrl

SAR conversion sequencer for the FRIDA ADC front end. It generates the sampling-phase clock that feeds `sampdriver.clk_in`, the comparator clock, and the capacitive-DAC trial code. It also runs the successive-approximation search and reports the result. It sits between the digital readout logic, which issues `start`, and the analog core: the sampling switch driver, the comparator and the DAC.

## Interface

Parameters:
- `N_BITS`, default 8: conversion resolution, and the width of `dac_state` and `result`.
- `SAMP_W`, default 4: width of the sample-length configuration.

Ports:
- `clk`, input, 1: single system clock. All logic is rising-edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `start`, input, 1: conversion request. Sampled only in IDLE or DONE.
- `samp_len`, input, SAMP_W: sample-phase length in `clk` cycles. 0 is treated as 1. Captured when `start` is accepted.
- `comp_out`, input, 1: comparator decision. 1 means input ≥ DAC. Sampled on the rising edge that ends each COMP cycle.
- `samp_clk`, output, 1: sampling phase. Drives `sampdriver.clk_in`. High only in SAMPLE.
- `comp_clk`, output, 1: comparator strobe. High only in COMP.
- `dac_state`, output, N_BITS: current DAC code, consisting of the kept bits plus the trial bit.
- `busy`, output, 1: high in SAMPLE, SETTLE and COMP.
- `done`, output, 1: one-cycle pulse in DONE.
- `result`, output, N_BITS: final code. Updated on entry to DONE and held until the next DONE.
- `vdd_d`, `vss_d`, inout, 1 each: digital supply pins. No logic function; passed through for netlist consistency.

## Operation

The block is a state machine with five states: IDLE, SAMPLE, SETTLE, COMP and DONE. It also holds a bit index `idx` of width ceil(log2(N_BITS)) and a sample counter `scnt` of width SAMP_W.

**IDLE**
- All outputs are 0, except `result`, which holds its last value.
- If `start`=1: capture `samp_len` into `scnt` (0 becomes 1) and go to SAMPLE.

**SAMPLE**
- `samp_clk`=1 and `dac_state`=0.
- Decrement `scnt` each cycle.
- Stay for exactly max(`samp_len`,1) cycles.
- On leaving: set `idx`=N_BITS-1 and go to SETTLE.

**SETTLE**
- `comp_clk`=0 and `samp_clk`=0.
- `dac_state` = kept bits | (1<<`idx`). This is the trial bit.
- Lasts one cycle, then go to COMP.

**COMP**
- `comp_clk`=1 and `dac_state` is unchanged from SETTLE.
- At the ending edge, bit `idx` of the kept register becomes `comp_out`.
- If `idx`=0: load `result` with the final kept code and go to DONE.
- Otherwise: decrement `idx` and go to SETTLE.

**DONE**
- `done`=1, `busy`=0, `dac_state` = final code.
- If `start`=1: go to SAMPLE immediately (back-to-back conversion, with `samp_len` recaptured).
- Otherwise go to IDLE.

Boundary conditions:
- `start` in SAMPLE, SETTLE or COMP is ignored. It is not queued.
- `samp_len` changes mid-conversion have no effect.
- `rst`=1 in any state takes effect at the next edge:
  - the state goes to IDLE;
  - all outputs become 0, including `result`;
  - the kept register and counters are cleared.
- `rst` has priority over `start`.
- `samp_clk` and `comp_clk` are never high in the same cycle. SETTLE guarantees one cycle of `samp_clk`-low before the first `comp_clk`.
- All outputs are registered: no combinational path from any input to any output.

## Timing

- **Latency.** Take the edge at which `start` is accepted as edge 0. Then:
  - SAMPLE occupies cycles 1..S, where S = max(`samp_len`,1);
  - bit k (MSB first, k = 0..N_BITS-1) occupies SETTLE at cycle S+1+2k and COMP at cycle S+2+2k;
  - DONE is at cycle S+2·N_BITS+1.
- **Throughput.** Back-to-back conversions repeat every S+2·N_BITS+1 cycles, with SAMPLE directly following DONE.
- **Comparator setup.** `comp_out` must be stable before the rising edge that ends each COMP cycle.
- **Reset values.** `samp_clk`=0, `comp_clk`=0, `dac_state`=0, `busy`=0, `done`=0, `result`=0.

## Test plan

All scenarios use N_BITS=8 and a comparator model with `comp_out` = (vin ≥ `dac_state`).

1. **Basic conversion.** `samp_len`=3, vin=0xA5, pulse `start` → `samp_clk` high cycles 1-3, `done` pulses at cycle 20, `result`=0xA5, `dac_state` sequence of trial codes 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
2. **Extremes.** vin=0x00 → `result`=0x00. vin=0xFF → `result`=0xFF. `comp_clk` pulses exactly 8 times per conversion and never overlaps `samp_clk`.
3. **Sample length.** `samp_len`=0 → SAMPLE lasts 1 cycle and `done` is at cycle 18. `samp_len`=15 → SAMPLE lasts 15 cycles and `done` is at cycle 32.
4. **Start handling.** `start` held high continuously → back-to-back conversions every 20 cycles with `samp_len`=3. `start` pulses during COMP are ignored, with no extra conversion.
5. **Reset.** Assert `rst` for one cycle during the 4th COMP → next cycle: all outputs 0 and IDLE. A fresh `start` then yields a correct result with nominal latency.
